// File: rtl/mem_dump_pkg.sv
// Shared types and helpers for the memory-to-UART dump engine.
package mem_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_FIN
  } state_t;

  localparam logic [7:0] HEX_LF = 8'h0A;

  function automatic int nb_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic logic [7:0] nib2hex(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/mem_dump_stream_hex_byte_serializer.sv
// Holds one captured word and walks it out as binary bytes or ASCII-hex
// characters over a valid/ack byte stream.
module hex_byte_serializer
  import mem_dump_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              hex_mode,
  input  logic              uart_ack,
  output logic              uart_valid,
  output logic [7:0]        uart_data,
  output logic              word_done
);

  localparam int NB    = nb_of(DATA_W);
  localparam int IDX_W = $clog2(2 * NB + 1);
  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(NB - 1);
  localparam logic [IDX_W-1:0] LAST_HEX = IDX_W'(2 * NB);

  logic [DATA_W-1:0] word_q;
  logic [IDX_W-1:0]  idx;
  logic              pend;
  logic [IDX_W-1:0]  last_idx;

  // Character i of a word: hex uses two indices per byte plus a trailing LF.
  function automatic logic [7:0] char_at(input logic [DATA_W-1:0] w, input logic hx,
                                         input logic [IDX_W-1:0] i);
    logic [IDX_W-1:0] pos;
    logic [IDX_W-1:0] bsel;
    logic [7:0]       bval;
    if (hx && i == LAST_HEX) return HEX_LF;
    pos  = hx ? (i >> 1) : i;
    bsel = (MSB_FIRST != 0) ? (LAST_BIN - pos) : pos;
    bval = 8'(w >> (8 * bsel));
    if (!hx) return bval;
    return nib2hex(i[0] ? bval[3:0] : bval[7:4]);
  endfunction

  assign last_idx  = hex_mode ? LAST_HEX : LAST_BIN;
  assign word_done = uart_valid && uart_ack && (idx == last_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q     <= '0;
      idx        <= '0;
      pend       <= 1'b0;
      uart_valid <= 1'b0;
      uart_data  <= '0;
    end else if (load) begin
      word_q     <= word;
      idx        <= '0;
      pend       <= 1'b0;
      uart_valid <= 1'b1;
      uart_data  <= char_at(word, hex_mode, '0);
    end else if (uart_valid && uart_ack) begin
      uart_valid <= 1'b0;
      if (idx != last_idx) begin
        idx  <= idx + IDX_W'(1);
        pend <= 1'b1;
      end
    end else if (pend) begin
      // one idle cycle between characters of the same word
      pend       <= 1'b0;
      uart_valid <= 1'b1;
      uart_data  <= char_at(word_q, hex_mode, idx);
    end
  end

endmodule

// File: rtl/mem_dump_stream.sv
// Dump engine: reads count words from base and streams them to the UART.
// state | meaning: IDLE wait start | FETCH issue read | WAIT read latency | SEND stream word | FIN done pulse
module mem_dump_stream
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  input  logic              hex_mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              uart_valid,
  output logic [7:0]        uart_data,
  input  logic              uart_ack,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remain_q;
  logic              hex_q;
  logic [1:0]        wait_cnt;
  logic              load;
  logic              word_done;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (count == '0) ? S_FIN : S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (wait_cnt == 2'd0) begin
          state_d = S_SEND;
          load    = 1'b1;
        end
      end
      S_SEND: begin
        if (word_done) state_d = (remain_q == (ADDR_W+1)'(1)) ? S_FIN : S_FETCH;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      hex_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        addr_q   <= base;
        remain_q <= count;
        hex_q    <= hex_mode;
      end
      if (state_q == S_FETCH) wait_cnt <= 2'(RD_LAT - 1);
      else if (state_q == S_WAIT && wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;
      if (state_q == S_SEND && word_done) begin
        addr_q   <= addr_q + ADDR_W'(1);
        remain_q <= remain_q - (ADDR_W+1)'(1);
      end
    end
  end

  assign mem_addr = addr_q;
  assign mem_rd   = (state_q == S_FETCH);
  assign busy     = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_SEND);
  assign done     = (state_q == S_FIN);

  hex_byte_serializer #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .word      (mem_data),
    .hex_mode  (hex_q),
    .uart_ack  (uart_ack),
    .uart_valid(uart_valid),
    .uart_data (uart_data),
    .word_done (word_done)
  );

endmodule

// File: tb/tb_mem_dump_stream.sv
// Bench for mem_dump_stream: a default instance and a 32-bit/MSB-first/RD_LAT=3 instance.
module tb_mem_dump_stream;

  localparam int BUDGET = 1500;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [13:0] base = '0;
  logic [14:0] count = '0;
  logic        hex_mode = 1'b0;
  logic        uart_ack = 1'b0;

  logic [13:0] mem_addr_a, mem_addr_b;
  logic        mem_rd_a, mem_rd_b;
  logic [15:0] mem_data_a;
  logic [31:0] mem_data_b;
  logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;
  logic [7:0]  data_a, data_b;

  logic [15:0] mem_a [16384];
  logic [31:0] mem_b [16384];
  logic [15:0] pd_a;
  logic        pv_a = 1'b0;
  logic [31:0] pd_b [3];
  logic [2:0]  pv_b = 3'b0;

  logic [7:0]  exp_bytes[$], got_bytes[$];
  logic [13:0] exp_addrs[$], got_addrs[$];
  int n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  mem_dump_stream dut_a (
    .clk(clk), .rst(rst), .start(start_a), .base(base), .count(count), .hex_mode(hex_mode),
    .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_data(mem_data_a),
    .uart_valid(valid_a), .uart_data(data_a), .uart_ack(uart_ack), .busy(busy_a), .done(done_a));

  mem_dump_stream #(.ADDR_W(14), .DATA_W(32), .RD_LAT(3), .MSB_FIRST(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .base(base), .count(count), .hex_mode(hex_mode),
    .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_data(mem_data_b),
    .uart_valid(valid_b), .uart_data(data_b), .uart_ack(uart_ack), .busy(busy_b), .done(done_b));

  // synchronous memories; data is garbage except exactly RD_LAT cycles after a read
  always @(posedge clk) begin
    pv_a    <= mem_rd_a;
    pd_a    <= mem_a[mem_addr_a];
    pv_b    <= {pv_b[1:0], mem_rd_b};
    pd_b[0] <= mem_b[mem_addr_b];
    pd_b[1] <= pd_b[0];
    pd_b[2] <= pd_b[1];
  end
  assign mem_data_a = pv_a ? pd_a : 16'hA5A5;
  assign mem_data_b = pv_b[2] ? pd_b[2] : 32'h5A5A_5A5A;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic build_model(input bit s, input logic [13:0] b, input logic [14:0] c, input bit hx);
    string hexs = "0123456789ABCDEF";
    exp_bytes.delete();
    exp_addrs.delete();
    for (int k = 0; k < int'(c); k++) begin
      logic [13:0] a;
      logic [31:0] w;
      int nb;
      a  = 14'((int'(b) + k) % 16384);
      w  = s ? mem_b[a] : {16'h0, mem_a[a]};
      nb = s ? 4 : 2;
      exp_addrs.push_back(a);
      for (int j = 0; j < nb; j++) begin
        int bi;
        int byt;
        bi  = s ? (nb - 1 - j) : j;
        byt = int'((w >> (8 * bi)) & 32'hFF);
        if (hx) begin
          exp_bytes.push_back(8'(hexs[byt / 16]));
          exp_bytes.push_back(8'(hexs[byt % 16]));
        end else begin
          exp_bytes.push_back(8'(byt));
        end
      end
      if (hx) exp_bytes.push_back(8'h0A);
    end
  endtask

  task automatic run(input bit s, input logic [13:0] b, input logic [14:0] c, input bit hx,
                     input int gap_max, input bit rnd, input bit restart, input string tag);
    int wait_v, gap, first_valid, done_cyc, n_done, tail, unstable;
    bit saw_valid, busy1, busy_at_done, v, rd, dn, bz;
    logic [7:0] d, held;
    logic [13:0] ad;
    build_model(s, b, c, hx);
    got_bytes.delete();
    got_addrs.delete();
    wait_v = 0; first_valid = -1; done_cyc = -1; n_done = 0; tail = 0; unstable = 0;
    saw_valid = 0; busy1 = 0; busy_at_done = 1; held = '0;
    @(negedge clk);
    base = b; count = c; hex_mode = hx; start_a = !s; start_b = s;
    @(negedge clk);
    start_a = 0; start_b = 0;
    base = 14'($urandom); count = 15'($urandom); hex_mode = 1'($urandom);
    gap = rnd ? $urandom_range(0, gap_max) : gap_max;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      v  = s ? valid_b : valid_a;
      d  = s ? data_b : data_a;
      rd = s ? mem_rd_b : mem_rd_a;
      ad = s ? mem_addr_b : mem_addr_a;
      dn = s ? done_b : done_a;
      bz = s ? busy_b : busy_a;
      if (cyc == 1) busy1 = bz;
      if (rd) got_addrs.push_back(ad);
      if (dn) begin
        n_done++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = bz; end
      end
      if (v) begin
        saw_valid = 1;
        if (first_valid < 0) first_valid = cyc;
      end
      start_a = 0; start_b = 0;
      if (restart && cyc == 4) begin
        start_a = !s; start_b = s; base = 14'h0123; count = 15'd7;
      end
      if (v) begin
        if (wait_v == 0) held = d;
        else if (d !== held) unstable++;
        if (wait_v >= gap) begin
          uart_ack = 1;
          got_bytes.push_back(d);
          wait_v = 0;
          gap = rnd ? $urandom_range(0, gap_max) : gap_max;
        end else begin
          uart_ack = 0;
          wait_v++;
        end
      end else begin
        uart_ack = rnd && ($urandom_range(0, 3) == 0);
        wait_v = 0;
      end
      if (n_done > 0) tail++;
      if (tail >= 4) break;
      @(negedge clk);
    end
    uart_ack = 0; start_a = 0; start_b = 0;
    check({tag, " done_count"}, n_done, 1);
    check({tag, " busy_at_done"}, busy_at_done, 0);
    check({tag, " busy_after_start"}, busy1, c != 0);
    check({tag, " saw_valid"}, saw_valid, c != 0);
    if (c == 0) check({tag, " done_cycle"}, done_cyc, 1);
    else check({tag, " first_valid_cycle"}, first_valid, s ? 5 : 3);
    check({tag, " byte_count"}, got_bytes.size(), exp_bytes.size());
    for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
      check($sformatf("%s byte%0d", tag, i), got_bytes[i], exp_bytes[i]);
    check({tag, " rd_count"}, got_addrs.size(), exp_addrs.size());
    for (int i = 0; i < exp_addrs.size() && i < got_addrs.size(); i++)
      check($sformatf("%s addr%0d", tag, i), got_addrs[i], exp_addrs[i]);
    check({tag, " data_stable"}, unstable, 0);
  endtask

  initial begin
    int acks, hit, late_done;
    for (int i = 0; i < 16384; i++) begin
      mem_a[i] = 16'($urandom);
      mem_b[i] = $urandom;
    end
    mem_a[16'h0010] = 16'hBEEF;
    mem_a[16'h0011] = 16'h1234;
    mem_b[0] = 32'hA1B2_C3D4;

    repeat (3) @(negedge clk);
    check("rst uart_valid", valid_a, 0);
    check("rst uart_data", data_a, 0);
    check("rst mem_rd", mem_rd_a, 0);
    check("rst mem_addr", mem_addr_a, 0);
    check("rst busy", busy_a, 0);
    check("rst done", done_a, 0);
    check("rst b_valid", valid_b, 0);
    rst = 0;

    run(0, 14'h0010, 15'd2, 0, 1, 0, 0, "bin");
    check("bin const", {got_bytes[0], got_bytes[1], got_bytes[2], got_bytes[3]}, 32'hEFBE_3412);
    run(0, 14'h0010, 15'd2, 1, 5, 0, 0, "hex");
    check("hex const", {got_bytes[0], got_bytes[1], got_bytes[2], got_bytes[3],
                        got_bytes[4], got_bytes[5], got_bytes[6], got_bytes[7]},
          64'h4546_4245_0A33_3431);
    check("hex tail", {got_bytes[8], got_bytes[9]}, 16'h320A);
    run(1, 14'h0000, 15'd1, 0, 1, 0, 0, "msb32");
    check("msb32 const", {got_bytes[0], got_bytes[1], got_bytes[2], got_bytes[3]}, 32'hA1B2_C3D4);
    run(0, 14'h3FFF, 15'd2, 0, 0, 0, 0, "wrap");
    run(1, 14'h3FFF, 15'd2, 1, 2, 0, 0, "wrap32hex");
    run(0, 14'h0100, 15'd0, 0, 0, 1, 0, "zero");
    run(0, 14'h0040, 15'd3, 1, 0, 0, 1, "restart");

    // reset while the second byte is pending
    @(negedge clk);
    base = 14'h0020; count = 15'd3; hex_mode = 0; start_a = 1;
    @(negedge clk);
    start_a = 0; acks = 0; hit = 0;
    for (int k = 0; k < 40 && hit == 0; k++) begin
      if (valid_a) begin
        if (acks == 0) begin uart_ack = 1; acks = 1; end
        else begin uart_ack = 0; rst = 1; hit = 1; end
      end else uart_ack = 0;
      @(negedge clk);
    end
    check("midrst reached", hit, 1);
    check("midrst valid", valid_a, 0);
    check("midrst done", done_a, 0);
    check("midrst busy", busy_a, 0);
    rst = 0;
    late_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_a || valid_a) late_done++;
    end
    check("midrst no_done", late_done, 0);
    run(0, 14'h0200, 15'd3, 0, 1, 0, 0, "after_rst");

    for (int t = 0; t < 10; t++) begin
      logic [13:0] rb;
      rb = ($urandom_range(0, 1) == 0) ? 14'($urandom) : 14'(16384 - $urandom_range(1, 3));
      run(1'($urandom), rb, 15'($urandom_range(1, 5)), 1'($urandom), 3, 1, t == 3,
          $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
